// File: rtl/hyper_todram_driver_if.sv
// Command/result bus between the todram command sequencer and the block mover.
// The sequencer drives commands through master; the mover returns results through slave.
interface hyper_todram_driver_if;
  logic [8:0]  MV_START_ADDR;
  logic [5:0]  MV_COUNT_REQ;
  logic [1:0]  MV_SECTION;
  logic [1:0]  MV_DRAM_SEL;
  logic        MV_ISSUE;
  logic [5:0]  MV_COUNT_SENT;
  logic        MV_WORKING;
  logic        MV_IRQ;
  logic        MV_ABRUPT;
  logic [24:0] MV_ANCILL;

  modport master (
    output MV_START_ADDR, MV_COUNT_REQ, MV_SECTION, MV_DRAM_SEL, MV_ISSUE,
    input  MV_COUNT_SENT, MV_WORKING, MV_IRQ, MV_ABRUPT, MV_ANCILL
  );

  modport slave (
    input  MV_START_ADDR, MV_COUNT_REQ, MV_SECTION, MV_DRAM_SEL, MV_ISSUE,
    output MV_COUNT_SENT, MV_WORKING, MV_IRQ, MV_ABRUPT, MV_ANCILL
  );
endinterface

// File: rtl/hyper_todram_driver.sv
// LSAB-to-DRAM command sequencer: per-section descriptors, round-robin arbitration,
// burst splitting to the block mover and per-section completion events.
module hyper_todram_driver #(
  parameter int MAX_BURST = 32,
  parameter int LEN_W     = 12
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CFG_WE,
  input  logic [1:0]            CFG_SECTION,
  input  logic [8:0]            CFG_ADDR,
  input  logic [LEN_W-1:0]      CFG_LEN,
  input  logic [1:0]            CFG_DRAM_SEL,
  input  logic [3:0]            SECT_READY,
  output logic [3:0]            SECT_ACTIVE,
  hyper_todram_driver_if.master mv,
  output logic                  EVT_VALID,
  output logic [1:0]            EVT_SECTION,
  output logic                  EVT_IRQ,
  output logic [LEN_W-1:0]      EVT_LEFT,
  output logic [24:0]           EVT_ANCILL
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_ISSUE, S_WAIT_START, S_WAIT_END, S_UPDATE
  } state_t;

  localparam logic [LEN_W-1:0] BURST_L = LEN_W'(MAX_BURST);

  state_t           state_q, state_d;
  logic [8:0]       addr_q [4];
  logic [8:0]       addr_d [4];
  logic [LEN_W-1:0] left_q [4];
  logic [LEN_W-1:0] left_d [4];
  logic [1:0]       dsel_q [4];
  logic [1:0]       dsel_d [4];
  logic [3:0]       active_q, active_d;
  logic [1:0]       rr_q, rr_d, sel_q, sel_d;
  logic [8:0]       mv_addr_q, mv_addr_d;
  logic [5:0]       mv_cnt_q, mv_cnt_d;
  logic [1:0]       mv_dsel_q, mv_dsel_d;
  logic             evt_valid_q, evt_valid_d, evt_irq_q, evt_irq_d;
  logic [1:0]       evt_sec_q, evt_sec_d;
  logic [LEN_W-1:0] evt_left_q, evt_left_d;
  logic [24:0]      evt_ancill_q, evt_ancill_d;

  logic [3:0]       cand;
  logic             pick_found;
  logic [1:0]       pick, idx;
  logic [5:0]       burst;
  logic [LEN_W-1:0] sent_len, new_left;
  logic             unused_abrupt;

  // An abrupt stop needs no special path: a short burst leaves the section
  // active and it is retried on a later arbitration round.
  assign unused_abrupt = mv.MV_ABRUPT;

  // Round robin: nearest candidate after the last-served section wins.
  always_comb begin
    cand       = active_q & SECT_READY;
    pick_found = 1'b0;
    pick       = rr_q;
    idx        = rr_q;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_q + 2'(k);
      if (!pick_found && cand[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  assign burst    = (left_q[pick] < BURST_L) ? left_q[pick][5:0] : 6'(MAX_BURST);
  assign sent_len = LEN_W'(mv.MV_COUNT_SENT);
  assign new_left = (left_q[sel_q] > sent_len) ? left_q[sel_q] - sent_len : '0;

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    sel_d        = sel_q;
    mv_addr_d    = mv_addr_q;
    mv_cnt_d     = mv_cnt_q;
    mv_dsel_d    = mv_dsel_q;
    addr_d       = addr_q;
    left_d       = left_q;
    dsel_d       = dsel_q;
    active_d     = active_q;
    evt_valid_d  = 1'b0;
    evt_sec_d    = evt_sec_q;
    evt_irq_d    = evt_irq_q;
    evt_left_d   = evt_left_q;
    evt_ancill_d = evt_ancill_q;
    case (state_q)
      S_IDLE: if (|cand) state_d = S_SELECT;
      S_SELECT: begin
        if (pick_found) begin
          sel_d     = pick;
          mv_addr_d = addr_q[pick];
          mv_cnt_d  = burst;
          mv_dsel_d = dsel_q[pick];
          state_d   = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE:      state_d = S_WAIT_START;
      S_WAIT_START: if (mv.MV_WORKING) state_d = S_WAIT_END;
      S_WAIT_END:   if (!mv.MV_WORKING) state_d = S_UPDATE;
      S_UPDATE: begin
        left_d[sel_q] = new_left;
        addr_d[sel_q] = addr_q[sel_q] + 9'(mv.MV_COUNT_SENT);
        rr_d          = sel_q;
        state_d       = S_IDLE;
        // Interrupt or exhausted length ends the section; new_left is 0 in the latter.
        if (mv.MV_IRQ || new_left == '0) begin
          active_d[sel_q] = 1'b0;
          evt_valid_d     = 1'b1;
          evt_sec_d       = sel_q;
          evt_irq_d       = mv.MV_IRQ;
          evt_left_d      = new_left;
          evt_ancill_d    = mv.MV_ANCILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (CFG_WE && !active_q[CFG_SECTION]) begin
      addr_d[CFG_SECTION]   = CFG_ADDR;
      left_d[CFG_SECTION]   = CFG_LEN;
      dsel_d[CFG_SECTION]   = CFG_DRAM_SEL;
      active_d[CFG_SECTION] = (CFG_LEN != '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      sel_q        <= '0;
      mv_addr_q    <= '0;
      mv_cnt_q     <= '0;
      mv_dsel_q    <= '0;
      active_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_sec_q    <= '0;
      evt_irq_q    <= 1'b0;
      evt_left_q   <= '0;
      evt_ancill_q <= '0;
      for (int s = 0; s < 4; s++) begin
        addr_q[s] <= '0;
        left_q[s] <= '0;
        dsel_q[s] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      sel_q        <= sel_d;
      mv_addr_q    <= mv_addr_d;
      mv_cnt_q     <= mv_cnt_d;
      mv_dsel_q    <= mv_dsel_d;
      active_q     <= active_d;
      evt_valid_q  <= evt_valid_d;
      evt_sec_q    <= evt_sec_d;
      evt_irq_q    <= evt_irq_d;
      evt_left_q   <= evt_left_d;
      evt_ancill_q <= evt_ancill_d;
      for (int s = 0; s < 4; s++) begin
        addr_q[s] <= addr_d[s];
        left_q[s] <= left_d[s];
        dsel_q[s] <= dsel_d[s];
      end
    end
  end

  assign SECT_ACTIVE      = active_q;
  assign mv.MV_START_ADDR = mv_addr_q;
  assign mv.MV_COUNT_REQ  = mv_cnt_q;
  assign mv.MV_SECTION    = sel_q;
  assign mv.MV_DRAM_SEL   = mv_dsel_q;
  assign mv.MV_ISSUE      = (state_q == S_ISSUE);
  assign EVT_VALID        = evt_valid_q;
  assign EVT_SECTION      = evt_sec_q;
  assign EVT_IRQ          = evt_irq_q;
  assign EVT_LEFT         = evt_left_q;
  assign EVT_ANCILL       = evt_ancill_q;

endmodule

// File: tb/tb_hyper_todram_driver.sv
// Bench for hyper_todram_driver: mover responder, descriptor-level reference model,
// directed scenarios followed by randomized traffic.
module tb_hyper_todram_driver;

  logic        CLK = 1'b0;
  logic        RST, CFG_WE;
  logic [1:0]  CFG_SECTION, CFG_DRAM_SEL;
  logic [8:0]  CFG_ADDR;
  logic [11:0] CFG_LEN;
  logic [3:0]  SECT_READY, SECT_ACTIVE;
  logic        EVT_VALID, EVT_IRQ;
  logic [1:0]  EVT_SECTION;
  logic [11:0] EVT_LEFT;
  logic [24:0] EVT_ANCILL;

  hyper_todram_driver_if mvif ();

  hyper_todram_driver #(.MAX_BURST(32), .LEN_W(12)) dut (
    .CLK(CLK), .RST(RST), .CFG_WE(CFG_WE), .CFG_SECTION(CFG_SECTION),
    .CFG_ADDR(CFG_ADDR), .CFG_LEN(CFG_LEN), .CFG_DRAM_SEL(CFG_DRAM_SEL),
    .SECT_READY(SECT_READY), .SECT_ACTIVE(SECT_ACTIVE), .mv(mvif),
    .EVT_VALID(EVT_VALID), .EVT_SECTION(EVT_SECTION), .EVT_IRQ(EVT_IRQ),
    .EVT_LEFT(EVT_LEFT), .EVT_ANCILL(EVT_ANCILL)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct { int sec; int irq; int left; int ancill; int deadline; } evt_t;
  typedef struct { int sec; int addr; int cnt; int dsel; } iss_t;

  // Reference model: descriptor contents per section and the last-served section.
  int         m_addr [4];
  int         m_left [4];
  int         m_dsel [4];
  logic [3:0] m_active;
  int         m_last;

  evt_t evt_q [$];
  iss_t iss_q [$];
  bit   inflight = 1'b0;
  iss_t cur;
  int   last_evt_sec = -1, last_evt_irq = -1, last_evt_left = -1, last_evt_ancill = -1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int model_pick();
    for (int k = 1; k <= 4; k++)
      if (m_active[(m_last + k) % 4] && SECT_READY[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 4; s++) begin
      m_addr[s] = 0; m_left[s] = 0; m_dsel[s] = 0;
    end
    m_active = 4'b0;
    m_last   = 0;
    evt_q.delete();
    iss_q.delete();
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Per-cycle monitor: command capture, command stability, completion events.
  initial forever begin
    @(negedge CLK);
    if (RST === 1'b1) begin
      if (mvif.MV_ISSUE === 1'b1) begin
        check("no_reissue_in_flight", {31'b0, inflight}, 32'd0);
        cur.sec  = int'(mvif.MV_SECTION);
        cur.addr = int'(mvif.MV_START_ADDR);
        cur.cnt  = int'(mvif.MV_COUNT_REQ);
        cur.dsel = int'(mvif.MV_DRAM_SEL);
        iss_q.push_back(cur);
        inflight = 1'b1;
      end else if (inflight) begin
        check("stable_addr", mvif.MV_START_ADDR, cur.addr);
        check("stable_cnt",  mvif.MV_COUNT_REQ,  cur.cnt);
        check("stable_sec",  mvif.MV_SECTION,    cur.sec);
        check("stable_dsel", mvif.MV_DRAM_SEL,   cur.dsel);
      end
      if (EVT_VALID !== 1'b0) begin
        if (evt_q.size() == 0) begin
          check("spurious_evt", EVT_VALID, 32'd0);
        end else begin
          evt_t e;
          e = evt_q.pop_front();
          check("evt_section", EVT_SECTION, e.sec);
          check("evt_irq",     EVT_IRQ,     e.irq);
          check("evt_left",    EVT_LEFT,    e.left);
          check("evt_ancill",  EVT_ANCILL,  e.ancill);
          last_evt_sec    = int'(EVT_SECTION);
          last_evt_irq    = int'(EVT_IRQ);
          last_evt_left   = int'(EVT_LEFT);
          last_evt_ancill = int'(EVT_ANCILL);
          $display("evt  sec=%0d irq=%0d left=%0d ancill=0x%0h", EVT_SECTION, EVT_IRQ, EVT_LEFT, EVT_ANCILL);
        end
      end else if (evt_q.size() > 0 && cyc > evt_q[0].deadline) begin
        check("evt_timeout", EVT_VALID, 32'd1);
        void'(evt_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_cfg(input int sec, input int addr, input int len, input int dsel);
    CFG_WE = 1'b1; CFG_SECTION = 2'(sec); CFG_ADDR = 9'(addr);
    CFG_LEN = 12'(len); CFG_DRAM_SEL = 2'(dsel);
    if (!m_active[sec]) begin
      m_addr[sec] = addr; m_left[sec] = len; m_dsel[sec] = dsel;
      m_active[sec] = (len != 0);
    end
    tick(1);
    CFG_WE = 1'b0;
  endtask

  // Plays the mover for one command. sent_arg < 0 means a full burst; rnd picks
  // random results and injects configuration / ready changes while the mover works.
  task automatic serve(input int sent_arg, input int irq_arg, input int ancill_arg,
                       input bit rnd, input bit do_rst, output iss_t got);
    int waited = 0;
    int s, req, sent, irq, ancill, hold;
    got = '{sec: -1, addr: -1, cnt: -1, dsel: -1};
    while (iss_q.size() == 0 && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    if (iss_q.size() == 0) begin
      check("issue_timeout", iss_q.size(), 32'd1);
      return;
    end
    if (waited > 0) begin
      @(posedge CLK);
      #1;
    end
    got = iss_q.pop_front();
    s = model_pick();
    check("issue_expected", (s >= 0) ? 32'd1 : 32'd0, 32'd1);
    if (s < 0) return;
    req = (m_left[s] < 32) ? m_left[s] : 32;
    check("issue_sec",  got.sec,  s);
    check("issue_addr", got.addr, m_addr[s]);
    check("issue_cnt",  got.cnt,  req);
    check("issue_dsel", got.dsel, m_dsel[s]);
    $display("cmd  sec=%0d addr=0x%03h cnt=%0d dsel=%0d", got.sec, got.addr, got.cnt, got.dsel);

    tick($urandom_range(2, 3));
    mvif.MV_WORKING = 1'b1;
    hold = $urandom_range(1, 4);
    for (int h = 0; h < hold; h++) begin
      if (rnd && ($urandom % 4 == 0)) SECT_READY = 4'($urandom_range(0, 15));
      if (rnd && ($urandom % 3 == 0))
        do_cfg($urandom % 4, $urandom % 512, ($urandom % 5 == 0) ? 0 : $urandom_range(1, 100), $urandom % 4);
      else
        tick(1);
    end

    if (do_rst) begin
      inflight = 1'b0;
      mvif.MV_WORKING = 1'b0;
      RST = 1'b0;
      tick(1);
      RST = 1'b1;
      model_reset();
      @(negedge CLK);
      check("rst_mv_issue",    mvif.MV_ISSUE,     32'd0);
      check("rst_sect_active", SECT_ACTIVE,       32'd0);
      check("rst_count_req",   mvif.MV_COUNT_REQ, 32'd0);
      @(posedge CLK);
      #1;
      return;
    end

    if (rnd) begin
      case ($urandom % 4)
        0, 1: begin sent = req; irq = 0; end
        2:    begin sent = $urandom_range(0, req); irq = 0; end
        default: begin sent = $urandom_range(0, req); irq = 1; end
      endcase
      ancill = int'($urandom & 32'h01FF_FFFF);
    end else begin
      sent   = (sent_arg < 0 || sent_arg > req) ? req : sent_arg;
      irq    = irq_arg;
      ancill = ancill_arg;
    end
    mvif.MV_COUNT_SENT = 6'(sent);
    mvif.MV_IRQ        = irq[0];
    mvif.MV_ABRUPT     = (sent < req) && (irq == 0);
    mvif.MV_ANCILL     = 25'(ancill);
    mvif.MV_WORKING    = 1'b0;
    inflight = 1'b0;

    m_left[s] = (m_left[s] > sent) ? m_left[s] - sent : 0;
    m_addr[s] = (m_addr[s] + sent) % 512;
    m_last    = s;
    if (irq != 0 || m_left[s] == 0) begin
      m_active[s] = 1'b0;
      evt_q.push_back('{sec: s, irq: irq, left: m_left[s], ancill: ancill, deadline: cyc + 8});
    end
    tick(4);
    check("sect_active", SECT_ACTIVE, m_active);
  endtask

  iss_t g;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; CFG_WE = 1'b0; CFG_SECTION = '0; CFG_ADDR = '0; CFG_LEN = '0;
    CFG_DRAM_SEL = '0; SECT_READY = '0;
    mvif.MV_COUNT_SENT = '0; mvif.MV_WORKING = 1'b0; mvif.MV_IRQ = 1'b0;
    mvif.MV_ABRUPT = 1'b0; mvif.MV_ANCILL = '0;
    model_reset();
    tick(3);
    @(negedge CLK);
    check("reset_active",  SECT_ACTIVE,        32'd0);
    check("reset_issue",   mvif.MV_ISSUE,      32'd0);
    check("reset_addr",    mvif.MV_START_ADDR, 32'd0);
    check("reset_cnt",     mvif.MV_COUNT_REQ,  32'd0);
    check("reset_evt",     EVT_VALID,          32'd0);
    check("reset_evtleft", EVT_LEFT,           32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    tick(2);

    // Single short transfer
    SECT_READY = 4'b0010;
    do_cfg(1, 'h010, 10, 2);
    serve(-1, 0, 'h123, 1'b0, 1'b0, g);
    check("t1_addr", g.addr, 'h010);
    check("t1_cnt",  g.cnt,  10);
    check("t1_evt_sec",  last_evt_sec,  1);
    check("t1_evt_left", last_evt_left, 0);
    check("t1_active1",  SECT_ACTIVE[1], 0);

    // Split into 32, 32, 6
    SECT_READY = 4'b0001;
    do_cfg(0, 'h000, 70, 0);
    serve(-1, 0, 1, 1'b0, 1'b0, g);
    check("t2_b0_addr", g.addr, 'h000);
    check("t2_b0_cnt",  g.cnt,  32);
    serve(-1, 0, 2, 1'b0, 1'b0, g);
    check("t2_b1_addr", g.addr, 'h020);
    check("t2_b1_cnt",  g.cnt,  32);
    serve(-1, 0, 3, 1'b0, 1'b0, g);
    check("t2_b2_addr", g.addr, 'h040);
    check("t2_b2_cnt",  g.cnt,  6);
    check("t2_evt_ancill", last_evt_ancill, 3);

    // Round robin after section 2 was served: 3 then 2
    SECT_READY = 4'b0100;
    do_cfg(2, 'h100, 5, 1);
    serve(-1, 0, 4, 1'b0, 1'b0, g);
    SECT_READY = 4'b0000;
    tick(1);
    do_cfg(2, 'h100, 4, 1);
    do_cfg(3, 'h180, 3, 3);
    SECT_READY = 4'b1100;
    serve(-1, 0, 5, 1'b0, 1'b0, g);
    check("t3_first_sec", g.sec, 3);
    check("t3_first_evt", last_evt_sec, 3);
    serve(-1, 0, 6, 1'b0, 1'b0, g);
    check("t3_second_sec", g.sec, 2);
    check("t3_second_evt", last_evt_sec, 2);

    // Interrupt ends the transfer early
    SECT_READY = 4'b0001;
    do_cfg(0, 'h050, 20, 0);
    serve(5, 1, 'h1ABCDEF, 1'b0, 1'b0, g);
    check("t4_evt_irq",    last_evt_irq,    1);
    check("t4_evt_left",   last_evt_left,   15);
    check("t4_evt_ancill", last_evt_ancill, 'h1ABCDEF);

    // Column address wraps
    do_cfg(0, 'h1F8, 16, 0);
    serve(8, 0, 7, 1'b0, 1'b0, g);
    check("t5_b0_addr", g.addr, 'h1F8);
    serve(8, 0, 8, 1'b0, 1'b0, g);
    check("t5_b1_addr", g.addr, 'h000);
    check("t5_b1_cnt",  g.cnt,  8);

    // Abrupt stop with nothing sent, then retry
    SECT_READY = 4'b0010;
    do_cfg(1, 'h020, 12, 1);
    serve(0, 0, 9, 1'b0, 1'b0, g);
    check("t6_still_active", SECT_ACTIVE[1], 1);
    serve(-1, 0, 10, 1'b0, 1'b0, g);
    check("t6_retry_addr", g.addr, 'h020);
    check("t6_retry_cnt",  g.cnt,  12);

    // Reset while the mover is working
    SECT_READY = 4'b0100;
    do_cfg(2, 'h040, 30, 2);
    serve(-1, 0, 0, 1'b0, 1'b1, g);
    tick(3);

    // Randomized traffic
    SECT_READY = 4'b0000;
    for (int r = 0; r < 200; r++) begin
      if ((m_active & SECT_READY) == 4'b0) begin
        int a;
        SECT_READY = 4'b0000;
        tick(1);
        for (int s = 0; s < 4; s++)
          if (!m_active[s] && ($urandom % 2 == 0))
            do_cfg(s, $urandom % 512, $urandom_range(1, 150), $urandom % 4);
        if (m_active == 4'b0) do_cfg(0, $urandom % 512, $urandom_range(1, 150), $urandom % 4);
        a = 0;
        for (int s = 3; s >= 0; s--) if (m_active[s]) a = s;
        SECT_READY = 4'($urandom_range(0, 15)) | (4'b0001 << a);
      end
      serve(-1, 0, 0, 1'b1, 1'b0, g);
    end

    tick(10);
    check("pending_events", evt_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
